// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: shifts address/data bytes on SDA, samples slave ACKs
// and read data, and issues START/STOP, all paced by the data_clk phase input.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus released, waiting for ena
// START    | generate START / repeated START, then drive address MSB
// ADDR     | shift out remaining address + rw bits
// SLV_ACK1 | slave acknowledges address
// WR       | shift out data byte
// RD       | shift in data byte from slave
// SLV_ACK2 | slave acknowledges written byte; decide continue/restart/stop
// MSTR_ACK | master ACK/NACK of read byte; decide continue/restart/stop
// STOP     | generate STOP, return to IDLE
module i2c_byte_master #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_clk,
   input  logic       ena,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] data_wr,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       scl_not_ena,
   output logic       busy,
   output logic [7:0] data_rd,
   output logic       ack_error
);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, SLV_ACK1, WR, RD, SLV_ACK2, MSTR_ACK, STOP
   } state_t;

   logic sda_s;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign sda_s = sda_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk) begin
            if (!rst) begin
               sync_q <= '1;
            end else begin
               sync_q[0] <= sda_i;
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end
         assign sda_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] addr_rw_q, addr_rw_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] data_rd_q, data_rd_d;
   logic       sda_oe_q, sda_oe_d;
   logic       scl_not_ena_q, scl_not_ena_d;
   logic       busy_q, busy_d;
   logic       ack_error_q, ack_error_d;
   logic       data_clk_q;

   logic       rise, fall;
   logic [7:0] req;

   assign rise = data_clk & ~data_clk_q;
   assign fall = ~data_clk & data_clk_q;
   assign req  = {addr, rw};

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      addr_rw_d     = addr_rw_q;
      tx_d          = tx_q;
      rx_d          = rx_q;
      data_rd_d     = data_rd_q;
      sda_oe_d      = sda_oe_q;
      scl_not_ena_d = scl_not_ena_q;
      busy_d        = busy_q;
      ack_error_d   = ack_error_q;
      if (rise) begin
         case (state_q)
            IDLE: begin
               if (ena) begin
                  addr_rw_d   = req;
                  tx_d        = data_wr;
                  busy_d      = 1'b1;
                  ack_error_d = 1'b0;
                  state_d     = START;
               end
            end
            START: begin
               sda_oe_d  = ~addr_rw_q[7];
               bit_cnt_d = 3'd7;
               state_d   = ADDR;
            end
            ADDR: begin
               if (bit_cnt_q == 3'd0) begin
                  sda_oe_d = 1'b0;
                  state_d  = SLV_ACK1;
               end else begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
                  sda_oe_d  = ~addr_rw_q[bit_cnt_q - 3'd1];
               end
            end
            SLV_ACK1: begin
               bit_cnt_d = 3'd7;
               if (!addr_rw_q[0]) begin
                  sda_oe_d = ~tx_q[7];
                  state_d  = WR;
               end else begin
                  sda_oe_d = 1'b0;
                  state_d  = RD;
               end
            end
            WR: begin
               if (bit_cnt_q == 3'd0) begin
                  sda_oe_d = 1'b0;
                  busy_d   = 1'b0;
                  state_d  = SLV_ACK2;
               end else begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
                  sda_oe_d  = ~tx_q[bit_cnt_q - 3'd1];
               end
            end
            RD: begin
               if (bit_cnt_q == 3'd0) begin
                  data_rd_d = rx_q;
                  busy_d    = 1'b0;
                  // ACK only when the user wants another byte of the same read
                  sda_oe_d  = ena && (req == addr_rw_q);
                  state_d   = MSTR_ACK;
               end else begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
               end
            end
            SLV_ACK2, MSTR_ACK: begin
               if (ena) begin
                  busy_d = 1'b1;
                  tx_d   = data_wr;
                  if (req == addr_rw_q) begin
                     bit_cnt_d = 3'd7;
                     if (!addr_rw_q[0]) begin
                        sda_oe_d = ~data_wr[7];
                        state_d  = WR;
                     end else begin
                        sda_oe_d = 1'b0;
                        state_d  = RD;
                     end
                  end else begin
                     addr_rw_d = req;
                     sda_oe_d  = 1'b0;
                     state_d   = START;
                  end
               end else begin
                  sda_oe_d = 1'b1;
                  state_d  = STOP;
               end
            end
            default: ;
         endcase
      end else if (fall) begin
         case (state_q)
            START: begin
               sda_oe_d      = 1'b1;
               scl_not_ena_d = 1'b0;
            end
            SLV_ACK1, SLV_ACK2: begin
               if (sda_s) ack_error_d = 1'b1;
            end
            RD: rx_d[bit_cnt_q] = sda_s;
            STOP: begin
               sda_oe_d      = 1'b0;
               scl_not_ena_d = 1'b1;
               busy_d        = 1'b0;
               state_d       = IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         bit_cnt_q     <= 3'd7;
         addr_rw_q     <= 8'h00;
         tx_q          <= 8'h00;
         rx_q          <= 8'h00;
         data_rd_q     <= 8'h00;
         sda_oe_q      <= 1'b0;
         scl_not_ena_q <= 1'b1;
         busy_q        <= 1'b0;
         ack_error_q   <= 1'b0;
         data_clk_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         addr_rw_q     <= addr_rw_d;
         tx_q          <= tx_d;
         rx_q          <= rx_d;
         data_rd_q     <= data_rd_d;
         sda_oe_q      <= sda_oe_d;
         scl_not_ena_q <= scl_not_ena_d;
         busy_q        <= busy_d;
         ack_error_q   <= ack_error_d;
         data_clk_q    <= data_clk;
      end
   end

   assign sda_oe      = sda_oe_q;
   assign scl_not_ena = scl_not_ena_q;
   assign busy        = busy_q;
   assign data_rd     = data_rd_q;
   assign ack_error   = ack_error_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: models the stretch generator phases and an I2C
// slave, decodes the bus into START/BYTE/STOP events and scores them.
module tb_i2c_byte_master;

   localparam int EV_START = 0;
   localparam int EV_BYTE  = 1;
   localparam int EV_STOP  = 2;

   typedef struct {
      int         kind;
      logic [7:0] val;
      logic       ack;
      logic       aerr;
      logic [7:0] drd;
      int         falls;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       data_clk, ena, rw, sda_i, sda_oe, scl_not_ena, busy, ack_error;
   logic [6:0] addr;
   logic [7:0] data_wr, data_rd;
   logic       scl;

   logic [1:0] ph = 2'd0;
   int         ph_cnt = 0;

   logic       slave_oe = 1'b0;
   logic       slave_ack_en = 1'b1;
   logic [7:0] rd_byte = 8'h00;
   logic       mon_en = 1'b0;

   int         checks = 0;
   int         errors = 0;
   ev_t        exp_q[$];

   logic       in_txn = 1'b0, is_read = 1'b0, nacked = 1'b0;
   logic       p_sda = 1'b1, p_scl = 1'b1, p_busy = 1'b0;
   logic [7:0] shreg = 8'h00;
   int         bit_idx = 0, byte_idx = 0, busy_falls = 0;

   i2c_byte_master #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .data_clk(data_clk), .ena(ena), .addr(addr),
      .rw(rw), .data_wr(data_wr), .sda_i(sda_i), .sda_oe(sda_oe),
      .scl_not_ena(scl_not_ena), .busy(busy), .data_rd(data_rd),
      .ack_error(ack_error)
   );

   always #5 clk = ~clk;

   // Four phases of four clocks: SCL low in 0-1, high in 2-3; data_clk high in 1-2.
   always @(posedge clk) begin
      if (ph_cnt == 3) begin
         ph_cnt <= 0;
         ph     <= ph + 2'd1;
      end else begin
         ph_cnt <= ph_cnt + 1;
      end
   end
   assign data_clk = (ph == 2'd1) || (ph == 2'd2);
   assign scl      = scl_not_ena | (ph == 2'd2) | (ph == 2'd3);
   assign sda_i    = ~(sda_oe | slave_oe);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_ev(input int kind, input logic [7:0] val, input logic ack,
                         input logic aerr, input logic [7:0] drd, input int falls);
      ev_t e;
      e.kind = kind; e.val = val; e.ack = ack; e.aerr = aerr; e.drd = drd; e.falls = falls;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [7:0] val, input logic ack);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d expected none", kind);
         return;
      end
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind && kind == EV_BYTE) begin
         chk("byte_value", val, e.val);
         chk("byte_ack", ack, e.ack);
      end
      if (kind == e.kind && kind == EV_STOP) begin
         chk("ack_error_at_stop", ack_error, e.aerr);
         chk("data_rd_at_stop", data_rd, e.drd);
         chk("busy_falls", busy_falls, e.falls);
      end
   endtask

   // Bus monitor and slave model.
   initial begin
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            in_txn = 1'b0; bit_idx = 0; byte_idx = 0; is_read = 1'b0;
            nacked = 1'b0; slave_oe = 1'b0;
         end else if (scl && p_scl && p_sda && !sda_i) begin
            if (!in_txn) busy_falls = 0;
            in_txn = 1'b1; bit_idx = 0; byte_idx = 0; nacked = 1'b0; slave_oe = 1'b0;
            observe(EV_START, 8'h00, 1'b0);
         end else if (scl && p_scl && !p_sda && sda_i) begin
            in_txn = 1'b0;
            observe(EV_STOP, 8'h00, 1'b0);
         end else if (in_txn && scl && !p_scl) begin
            if (bit_idx < 8) begin
               shreg = {shreg[6:0], sda_i};
               bit_idx++;
            end else begin
               observe(EV_BYTE, shreg, sda_i);
               if (byte_idx == 0) is_read = shreg[0];
               else if (is_read && sda_i) nacked = 1'b1;
               byte_idx++;
               bit_idx = 0;
            end
         end else if (in_txn && !scl && p_scl) begin
            slave_oe = 1'b0;
            if (bit_idx == 8) begin
               if (byte_idx == 0 || !is_read) slave_oe = slave_ack_en;
            end else if (is_read && byte_idx > 0 && !nacked) begin
               slave_oe = ~rd_byte[7 - bit_idx];
            end
         end
         if (mon_en && in_txn && p_busy && !busy) busy_falls++;
         p_sda = sda_i; p_scl = scl; p_busy = busy;
      end
   end

   task automatic wait_busy(input logic v, input string what);
      int n = 0;
      while (busy !== v && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (busy !== v) begin
         checks++;
         errors++;
         $display("FAIL %s: busy timeout, got %b expected %b", what, busy, v);
      end
   endtask

   task automatic drain(input string what);
      int n = 0;
      while (exp_q.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s: %0d events outstanding, expected 0", what, exp_q.size());
         exp_q.delete();
      end
      repeat (40) @(negedge clk);
   endtask

   task automatic start_txn(input logic [6:0] a, input logic r, input logic [7:0] d);
      @(negedge clk);
      addr = a; rw = r; data_wr = d; ena = 1'b1;
   endtask

   initial begin
      ena = 1'b0; addr = 7'h00; rw = 1'b0; data_wr = 8'h00;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sda_oe", sda_oe, 1'b0);
      chk("rst_scl_not_ena", scl_not_ena, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ack_error", ack_error, 1'b0);
      chk("rst_data_rd", data_rd, 8'h00);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      mon_en = 1'b1;

      // single write 0x50 <- 0xA5
      exp_ev(EV_START, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'hA0, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'hA5, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_STOP,  8'h00, 1'b0, 1'b0, 8'h00, 1);
      start_txn(7'h50, 1'b0, 8'hA5);
      wait_busy(1'b1, "wr_busy_rise");
      ena = 1'b0;
      drain("wr_single");

      // single read from 0x3C, slave returns 0x96, master NACKs
      rd_byte = 8'h96;
      exp_ev(EV_START, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'h79, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'h96, 1'b1, 1'b0, 8'h00, 0);
      exp_ev(EV_STOP,  8'h00, 1'b0, 1'b0, 8'h96, 1);
      start_txn(7'h3C, 1'b1, 8'h00);
      wait_busy(1'b1, "rd_busy_rise");
      ena = 1'b0;
      drain("rd_single");

      // no slave present: both ACK slots see SDA high
      slave_ack_en = 1'b0;
      exp_ev(EV_START, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'hA0, 1'b1, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'h33, 1'b1, 1'b0, 8'h00, 0);
      exp_ev(EV_STOP,  8'h00, 1'b0, 1'b1, 8'h96, 1);
      start_txn(7'h50, 1'b0, 8'h33);
      wait_busy(1'b1, "nack_busy_rise");
      ena = 1'b0;
      drain("addr_nack");
      chk("ack_error_sticky_idle", ack_error, 1'b1);
      slave_ack_en = 1'b1;

      // burst write 0x11, 0x22 with ena held
      exp_ev(EV_START, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'hA0, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'h11, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'h22, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_STOP,  8'h00, 1'b0, 1'b0, 8'h96, 2);
      start_txn(7'h50, 1'b0, 8'h11);
      wait_busy(1'b1, "burst_busy_rise1");
      chk("ack_error_cleared_on_start", ack_error, 1'b0);
      wait_busy(1'b0, "burst_busy_fall1");
      data_wr = 8'h22;
      wait_busy(1'b1, "burst_busy_rise2");
      ena = 1'b0;
      drain("burst_write");

      // write 0x5A then repeated START into a read returning 0xC3
      rd_byte = 8'hC3;
      exp_ev(EV_START, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'hA0, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'h5A, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_START, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'hA1, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'hC3, 1'b1, 1'b0, 8'h00, 0);
      exp_ev(EV_STOP,  8'h00, 1'b0, 1'b0, 8'hC3, 2);
      start_txn(7'h50, 1'b0, 8'h5A);
      wait_busy(1'b1, "rs_busy_rise1");
      wait_busy(1'b0, "rs_busy_fall1");
      rw = 1'b1;
      wait_busy(1'b1, "rs_busy_rise2");
      ena = 1'b0;
      drain("repeated_start");

      // reset in the middle of a read byte
      mon_en = 1'b0;
      start_txn(7'h3C, 1'b1, 8'h00);
      wait_busy(1'b1, "abort_busy_rise");
      ena = 1'b0;
      repeat (13) @(posedge data_clk);
      repeat (4) @(negedge clk);
      chk("busy_before_rst", busy, 1'b1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrd_rst_sda_oe", sda_oe, 1'b0);
      chk("midrd_rst_scl_not_ena", scl_not_ena, 1'b1);
      chk("midrd_rst_busy", busy, 1'b0);
      chk("midrd_rst_ack_error", ack_error, 1'b0);
      chk("midrd_rst_data_rd", data_rd, 8'h00);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      exp_ev(EV_START, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'hA0, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_BYTE,  8'h0F, 1'b0, 1'b0, 8'h00, 0);
      exp_ev(EV_STOP,  8'h00, 1'b0, 1'b0, 8'h00, 1);
      start_txn(7'h50, 1'b0, 8'h0F);
      wait_busy(1'b1, "post_rst_busy_rise");
      ena = 1'b0;
      drain("post_reset_write");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
